// File: rtl/muldiv_seq.sv
// Multi-cycle RV32 M-extension unit: one shared 64-bit shift/add-subtract register
// iterated 32 times for MUL*/DIV*/REM*, with sign fix-up and special cases up front.
module muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [2:0]     r_funct3;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_signA;
    logic           r_signB;
    logic [5:0]     r_cnt;
    logic [2*W-1:0] r_acc;
    logic           r_special;
    logic [W-1:0]   r_preset;
    logic [W-1:0]   r_result;

    logic           w_accept;
    logic           w_op1Signed;
    logic           w_op2Signed;
    logic           w_signA;
    logic           w_signB;
    logic [W-1:0]   w_mag1;
    logic [W-1:0]   w_mag2;
    logic           w_divZero;
    logic           w_overflow;
    logic           w_special;
    logic [W-1:0]   w_specVal;
    logic [W:0]     w_mulSum;
    logic [2*W-1:0] w_mulNext;
    logic [W:0]     w_divShift;
    logic [W:0]     w_divDiff;
    logic           w_divGe;
    logic [2*W-1:0] w_divNext;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_fixResult;

    assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
    assign w_op1Signed = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    assign w_op2Signed = (funct3 == 3'b000 || funct3 == 3'b001 ||
                          funct3 == 3'b100 || funct3 == 3'b110);
    assign w_signA     = w_op1Signed && op1[W-1];
    assign w_signB     = w_op2Signed && op2[W-1];
    assign w_mag1      = w_signA ? -op1 : op1;
    assign w_mag2      = w_signB ? -op2 : op2;

    // Divide-by-zero and signed overflow bypass the iteration with a preset result.
    assign w_divZero   = funct3[2] && (op2 == '0);
    assign w_overflow  = funct3[2] && !funct3[0] && (op1 == MIN_NEG) && (op2 == '1);
    assign w_special   = w_divZero || w_overflow;
    assign w_specVal   = w_divZero ? (funct3[1] ? op1 : '1) : (funct3[1] ? '0 : MIN_NEG);

    assign w_mulSum    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mulNext   = {w_mulSum, r_acc[W-1:1]};

    // Remainder shifted left with the next dividend bit can need W+1 bits.
    assign w_divShift  = r_acc[2*W-1:W-1];
    assign w_divDiff   = w_divShift - {1'b0, r_b};
    assign w_divGe     = (w_divShift >= {1'b0, r_b});
    assign w_divNext   = {(w_divGe ? w_divDiff[W-1:0] : w_divShift[W-1:0]), r_acc[W-2:0], w_divGe};

    assign w_prod      = (r_signA ^ r_signB) ? -r_acc : r_acc;
    assign w_quo       = (r_signA ^ r_signB) ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem       = r_signA ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_comb begin
        w_fixResult = '0;
        case (r_funct3)
            3'b000:                 w_fixResult = w_prod[W-1:0];
            3'b001, 3'b010, 3'b011: w_fixResult = w_prod[2*W-1:W];
            3'b100, 3'b101:         w_fixResult = w_quo;
            default:                w_fixResult = w_rem;
        endcase
        if (r_special) begin
            w_fixResult = r_preset;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (start) w_nextState = w_special ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == 6'd31) w_nextState = S_FIX;
            S_FIX:  w_nextState = S_DONE;
            S_DONE: begin
                if (start) w_nextState = w_special ? S_FIX : S_CALC;
                else       w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
        if (flush) begin
            w_nextState = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_funct3  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_special <= 1'b0;
            r_preset  <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_funct3  <= funct3;
            r_a       <= w_mag1;
            r_b       <= w_mag2;
            r_signA   <= w_signA;
            r_signB   <= w_signB;
            r_cnt     <= '0;
            r_acc     <= {{W{1'b0}}, (funct3[2] ? w_mag1 : w_mag2)};
            r_special <= w_special;
            r_preset  <= w_specVal;
        end else if (r_state == S_CALC && !flush) begin
            r_cnt     <= r_cnt + 6'd1;
            r_acc     <= r_funct3[2] ? w_divNext : w_mulNext;
        end else if (r_state == S_FIX && !flush) begin
            r_result  <= w_fixResult;
        end
    end

    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed cases plus random ops checked
// against a plain 64-bit arithmetic model of the M-extension rules.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int unsigned doneCyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        popped;
    int unsigned cyc = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] lastExp = '0;

    muldiv_seq #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: full-width signed/unsigned products and truncating division.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sbv;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sbv; return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sbv; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sbv; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Whenever done shows, the oldest outstanding expectation must match it.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                popped = sb.pop_front();
                checkOutput("result", result, popped.res);
                checkOutput("done_cycle", cyc, popped.doneCyc);
            end
        end
    end

    task automatic waitCycle(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input bit doPush,
                                 output int unsigned acceptEdge);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (busy) checkOutput("accept_timeout", {31'b0, busy}, 32'h0);
        funct3     = f;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        acceptEdge = cyc + 1;
        if (doPush) begin
            e.res     = expRes;
            e.doneCyc = acceptEdge + (isSpecial(f, a, b) ? 1 : 33);
            sb.push_back(e);
            lastExp   = expRes;
        end
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    logic [2:0]  dirF [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] dirA [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dirB [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
                               32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dirE [10] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0};

    initial begin
        int unsigned k;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        funct3 = '0;
        op1 = '0;
        op2 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        checkOutput("reset_result", result, 32'h0);
        rst_n = 1'b1;

        // MUL 7 x -3 with busy window checks
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, k);
        checkOutput("mul_busy_start", {31'b0, busy}, 32'h1);
        waitCycle(k + 32);
        checkOutput("mul_busy_last", {31'b0, busy}, 32'h1);
        waitCycle(k + 33);
        checkOutput("mul_busy_done", {31'b0, busy}, 32'h0);
        drain();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(dirF[i], dirA[i], dirB[i], dirE[i], 1'b1, k);
        end
        drain();

        // flush at edge 10 of a DIVU
        applyStimulus(3'd5, 32'hDEAD_BEEF, 32'd3, 32'h0, 1'b0, k);
        waitCycle(k + 9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clk);
        checkOutput("flush_result_kept", result, lastExp);

        // reset at edge 20 of a MUL
        applyStimulus(3'd0, 32'd9, 32'd9, 32'h0, 1'b0, k);
        waitCycle(k + 19);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_done", {31'b0, done}, 32'h0);
        checkOutput("rst_result", result, 32'h0);
        rst_n = 1'b1;
        lastExp = '0;

        // start pulsed while busy must be ignored
        applyStimulus(3'd4, 32'd100, 32'd7, 32'd14, 1'b1, k);
        waitCycle(k + 5);
        start = 1'b1;
        funct3 = 3'd3;
        op1 = $urandom;
        op2 = $urandom;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high: MUL 3 x 5 repeats every 34 cycles
        @(negedge clk);
        funct3 = 3'd0;
        op1 = 32'd3;
        op2 = 32'd5;
        start = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{res: 32'd15, doneCyc: k + 33 + 34 * i});
        end
        waitCycle(k + 101);
        start = 1'b0;
        drain();

        for (int i = 0; i < 120; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus(rf, ra, rb, refModel(rf, ra, rb), 1'b1, k);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
